// File: rtl/nibbler_bus_pkg.sv
// +----------------------------------------------------------------------------+
// | nibbler_bus_pkg : shared types for the nibbler 4-bit data bus.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package nibbler_bus_pkg;

  localparam int BUS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// +----------------------------------------------------------------------------+
// | rr_picker : combinational round-robin winner select, starting after        |
// |             last_owner_i and wrapping, so last_owner_i has lowest priority. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_picker
  import nibbler_bus_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_owner_i,
  output logic [$clog2(N_REQ)-1:0] winner_o,
  output logic                     any_req_o
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   upper_mask;
  logic [2*N_REQ-1:0] dbl_req;
  logic               found;

  // Lower copy keeps only bits above the pointer; upper copy covers the wrap.
  always_comb begin
    upper_mask = '0;
    for (int j = 0; j < N_REQ; j++) begin
      upper_mask[j] = (j > int'(last_owner_i));
    end
    dbl_req  = {req_i, req_i & upper_mask};
    winner_o = '0;
    found    = 1'b0;
    for (int i = 0; i < 2*N_REQ; i++) begin
      if (!found && dbl_req[i]) begin
        found    = 1'b1;
        winner_o = IW'(i % N_REQ);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | bus_arbiter : round-robin owner scheduling for the shared tri-state bus,   |
// |               with bounded hold under contention and dead-cycle turnaround.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_arbiter
  import nibbler_bus_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         enable_port,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     bus_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = cnt_width(MAX_HOLD);
  localparam int TW = cnt_width(TURN_CYC);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [IW-1:0] PTR_RESET = IW'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] enable_q, enable_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [IW-1:0]    last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    turn_q, turn_d;

  logic [IW-1:0]    winner;
  logic             any_req;
  logic [N_REQ-1:0] winner_onehot;
  logic             contend;

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i        (req),
    .last_owner_i (last_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  assign winner_onehot = N_REQ'(1) << winner;
  // In GRANT enable_q is the owner's one-hot, so this is "anyone else waiting".
  assign contend       = |(req & ~enable_q);

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    last_d   = last_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANT;
          enable_d = winner_onehot;
          grant_d  = winner;
          busy_d   = 1'b1;
          last_d   = winner;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (!req[grant_q] || (hold_q == HOLD_LAST && contend)) begin
          state_d  = TURN;
          enable_d = '0;
          busy_d   = 1'b0;
          turn_d   = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          if (any_req) begin
            state_d  = GRANT;
            enable_d = winner_onehot;
            grant_d  = winner;
            busy_d   = 1'b1;
            last_d   = winner;
            hold_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      enable_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      last_q   <= PTR_RESET;
      hold_q   <= '0;
      turn_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
    end
  end

  assign enable_port = enable_q;
  assign grant_id    = grant_q;
  assign bus_busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_bus_arbiter : self-checking bench for bus_arbiter (N=4, hold 8, turn 1).|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_bus_arbiter;

  localparam int N          = 4;
  localparam int MAX_HOLD   = 8;
  localparam int TURN_CYC   = 1;
  localparam int FAIR_BOUND = (N - 1) * (MAX_HOLD + TURN_CYC) + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] enable_port;
  logic [1:0]   grant_id;
  logic         bus_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: current owner (-1 = none), cycles owned so far,
  // dead cycles still to run, and the most recent owner.
  int m_owner;
  int m_run;
  int m_gap;
  int m_last;

  bus_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MAX_HOLD),
    .TURN_CYC (TURN_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .enable_port (enable_port),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_enable(input int owner);
    if (owner < 0) return '0;
    return N'(1) << owner;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_gap   = 0;
    m_last  = N - 1;
  endtask

  task automatic model_take(input logic [N-1:0] r);
    int w;
    w = rr_pick(r, m_last);
    if (w >= 0) begin
      m_owner = w;
      m_last  = w;
      m_run   = 1;
    end
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic others;
    if (m_owner >= 0) begin
      others = |(r & ~model_enable(m_owner));
      if (!r[m_owner] || (m_run >= MAX_HOLD && others)) begin
        m_owner = -1;
        m_gap   = TURN_CYC;
      end else begin
        m_run++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_take(r);
    end else begin
      model_take(r);
    end
  endtask

  task automatic drive_cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (enable_port !== 4'b0000 || grant_id !== 2'd0 || bus_busy !== 1'b0) begin
      $display("FAIL reset: enable=%b grant=%0d busy=%b, expected 0000 0 0",
               enable_port, grant_id, bus_busy);
    end else n_pass++;
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(4'b0000);
    n_checks++;
    if (enable_port !== 4'b0000 || bus_busy !== 1'b0) begin
      $display("FAIL idle_no_req: enable=%b busy=%b, expected 0000 0", enable_port, bus_busy);
    end else n_pass++;
  endtask

  task automatic test_first_grant();
    apply_reset();
    drive_cycle(4'b0001);
    n_checks++;
    if (enable_port !== 4'b0001 || grant_id !== 2'd0 || bus_busy !== 1'b1) begin
      $display("FAIL first_grant: enable=%b grant=%0d busy=%b, expected 0001 0 1",
               enable_port, grant_id, bus_busy);
    end else n_pass++;
    drive_cycle(4'b0000);
    n_checks++;
    if (enable_port !== 4'b0000 || bus_busy !== 1'b0) begin
      $display("FAIL release: enable=%b busy=%b, expected 0000 0", enable_port, bus_busy);
    end else n_pass++;
  endtask

  task automatic test_handoff();
    apply_reset();
    drive_cycle(4'b0101);
    n_checks++;
    if (enable_port !== 4'b0001 || grant_id !== 2'd0) begin
      $display("FAIL handoff_first: enable=%b grant=%0d, expected 0001 0", enable_port, grant_id);
    end else n_pass++;
    drive_cycle(4'b0100);
    n_checks++;
    if (enable_port !== 4'b0000 || bus_busy !== 1'b0) begin
      $display("FAIL handoff_dead: enable=%b busy=%b, expected 0000 0", enable_port, bus_busy);
    end else n_pass++;
    drive_cycle(4'b0100);
    n_checks++;
    if (enable_port !== 4'b0100 || grant_id !== 2'd2 || bus_busy !== 1'b1) begin
      $display("FAIL handoff_second: enable=%b grant=%0d busy=%b, expected 0100 2 1",
               enable_port, grant_id, bus_busy);
    end else n_pass++;
  endtask

  task automatic test_contention();
    int           pos;
    logic [N-1:0] exp_en;
    logic [1:0]   exp_id;
    apply_reset();
    for (int c = 0; c < 3 * 2 * (MAX_HOLD + TURN_CYC); c++) begin
      drive_cycle(4'b0011);
      pos    = c % (2 * (MAX_HOLD + TURN_CYC));
      exp_en = (pos < MAX_HOLD) ? 4'b0001 :
               (pos == MAX_HOLD) ? 4'b0000 :
               (pos < 2 * MAX_HOLD + 1) ? 4'b0010 : 4'b0000;
      exp_id = (pos < MAX_HOLD) ? 2'd0 : 2'd1;
      n_checks++;
      if (enable_port !== exp_en || (exp_en != 0 && grant_id !== exp_id)) begin
        $display("FAIL contention c=%0d: enable=%b grant=%0d, expected %b %0d",
                 c, enable_port, grant_id, exp_en, exp_id);
      end else n_pass++;
    end
  endtask

  task automatic test_single_hold();
    apply_reset();
    for (int c = 0; c < 21; c++) begin
      drive_cycle(4'b1000);
      n_checks++;
      if (enable_port !== 4'b1000 || grant_id !== 2'd3 || bus_busy !== 1'b1) begin
        $display("FAIL single_hold c=%0d: enable=%b grant=%0d busy=%b, expected 1000 3 1",
                 c, enable_port, grant_id, bus_busy);
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) drive_cycle(4'b1000);
    n_checks++;
    if (enable_port !== 4'b1000) begin
      $display("FAIL async_pre: enable=%b, expected 1000", enable_port);
    end else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (enable_port !== 4'b0000 || bus_busy !== 1'b0 || grant_id !== 2'd0) begin
      $display("FAIL async_drop: enable=%b busy=%b grant=%0d, expected 0000 0 0",
               enable_port, bus_busy, grant_id);
    end else n_pass++;
    #2;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(4'b1001);
    n_checks++;
    if (enable_port !== 4'b0001 || grant_id !== 2'd0) begin
      $display("FAIL async_regrant: enable=%b grant=%0d, expected 0001 0", enable_port, grant_id);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] prev_en;
    logic [N-1:0] exp_en;
    int           wait_cnt [N];
    apply_reset();
    r       = '0;
    prev_en = '0;
    for (int b = 0; b < N; b++) wait_cnt[b] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      drive_cycle(r);
      exp_en = model_enable(m_owner);
      n_checks++;
      if (enable_port !== exp_en || bus_busy !== (exp_en != 0) ||
          (exp_en != 0 && grant_id !== 2'(m_owner))) begin
        $display("FAIL random_model c=%0d req=%b: enable=%b grant=%0d busy=%b, expected %b %0d %b",
                 c, r, enable_port, grant_id, bus_busy, exp_en, m_owner, exp_en != 0);
      end else n_pass++;
      n_checks++;
      if (!$onehot0(enable_port)) begin
        $display("FAIL random_onehot c=%0d: enable=%b, expected at most one bit", c, enable_port);
      end else n_pass++;
      n_checks++;
      if (prev_en != 0 && enable_port != 0 && enable_port != prev_en) begin
        $display("FAIL random_turnaround c=%0d: enable %b -> %b, expected a zero cycle between",
                 c, prev_en, enable_port);
      end else n_pass++;
      for (int b = 0; b < N; b++) begin
        if (r[b] && !enable_port[b]) wait_cnt[b]++;
        else wait_cnt[b] = 0;
      end
      n_checks++;
      if (wait_cnt[0] > FAIR_BOUND || wait_cnt[1] > FAIR_BOUND ||
          wait_cnt[2] > FAIR_BOUND || wait_cnt[3] > FAIR_BOUND) begin
        $display("FAIL random_fairness c=%0d: waits %0d %0d %0d %0d, required <= %0d",
                 c, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3], FAIR_BOUND);
        for (int b = 0; b < N; b++) wait_cnt[b] = 0;
      end else n_pass++;
      prev_en = enable_port;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_handoff();
    test_contention();
    test_single_hold();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
